// File: rtl/scene_recovery_pkg.sv
// Shared defaults and state encoding for the dehaze scene-recovery pipeline.
package scene_recovery_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int T_W_DEF      = 8;
  localparam int T_MIN_DEF    = 26;
  localparam int CHANNELS_DEF = 3;
  localparam int N_DEF        = DATA_W_DEF + T_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/scene_recovery_pipe_seq_divider.sv
// Restoring bit-serial divider: one quotient bit per cycle, MSB first, NUM_W cycles after start.
module seq_divider #(
  parameter int NUM_W = 16,
  parameter int DEN_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [NUM_W-1:0] quo
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] shreg_q, shreg_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;

  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  always_comb begin
    shreg_d = shreg_q;
    rem_d   = rem_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    trial   = {rem_q, shreg_q[NUM_W-1]};
    diff    = trial - {1'b0, den_q};
    if (start) begin
      shreg_d = num;
      rem_d   = '0;
      den_d   = den;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, den_q}) begin
        rem_d   = diff[DEN_W-1:0];
        shreg_d = {shreg_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d   = trial[DEN_W-1:0];
        shreg_d = {shreg_q[NUM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(NUM_W - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign quo = shreg_q;

endmodule

// File: rtl/scene_recovery_pipe.sv
// Multi-channel dehaze recovery J = A + (I - A)/t with t floored, one shared handshake, saturating output.
module scene_recovery_pipe
  import scene_recovery_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int T_W      = T_W_DEF,
  parameter int T_MIN    = T_MIN_DEF
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_pix,
  input  logic [CHANNELS*DATA_W-1:0]   in_atm,
  input  logic [T_W-1:0]               in_t,
  input  logic                         bypass,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_pix,
  output logic                         out_clamp
);

  localparam int N     = DATA_W + T_W;
  localparam int CNT_W = $clog2(N + 1);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [CHANNELS*DATA_W-1:0]   pix_q, pix_d;
  logic [CHANNELS*DATA_W-1:0]   atm_q, atm_d;
  logic [CHANNELS-1:0]          sign_q, sign_d;
  logic                         bypass_q, bypass_d;
  logic [CHANNELS*DATA_W-1:0]   out_pix_q, out_pix_d;
  logic                         out_clamp_q, out_clamp_d;

  logic                         start;
  logic [T_W-1:0]               t_eff;
  logic [CHANNELS-1:0]          sign_in;
  logic [CHANNELS-1:0]          clamp_vec;
  logic [CHANNELS*DATA_W-1:0]   j_vec;

  assign start = (state_q == IDLE) && in_valid;
  assign t_eff = (in_t < T_W'(T_MIN)) ? T_W'(T_MIN) : in_t;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DATA_W-1:0] i_in, a_in, d_in, a_cap, j_c;
      logic [N-1:0]      quo;
      logic [N:0]        sum;
      logic              clamp_c;

      assign i_in        = in_pix[gi*DATA_W +: DATA_W];
      assign a_in        = in_atm[gi*DATA_W +: DATA_W];
      assign sign_in[gi] = i_in > a_in;
      assign d_in        = sign_in[gi] ? (i_in - a_in) : (a_in - i_in);
      assign a_cap       = atm_q[gi*DATA_W +: DATA_W];

      // The divider loads straight from the port on the accept edge so its N steps start immediately.
      seq_divider #(.NUM_W(N), .DEN_W(T_W)) u_div (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .num     ({d_in, {T_W{1'b0}}}),
        .den     (t_eff),
        .quo     (quo)
      );

      always_comb begin
        sum     = {1'b0, {T_W{1'b0}}, a_cap} + {1'b0, quo};
        clamp_c = 1'b0;
        j_c     = '0;
        if (sign_q[gi]) begin
          clamp_c = sum > {{(N+1-DATA_W){1'b0}}, {DATA_W{1'b1}}};
          j_c     = clamp_c ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
        end else begin
          clamp_c = quo > {{T_W{1'b0}}, a_cap};
          j_c     = clamp_c ? '0 : (a_cap - quo[DATA_W-1:0]);
        end
      end

      assign j_vec[gi*DATA_W +: DATA_W] = j_c;
      assign clamp_vec[gi]              = clamp_c;
    end
  endgenerate

  // Count N is the extra cycle in which the finished quotient is saturated and registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pix_d       = pix_q;
    atm_d       = atm_q;
    sign_d      = sign_q;
    bypass_d    = bypass_q;
    out_pix_d   = out_pix_q;
    out_clamp_d = out_clamp_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          pix_d    = in_pix;
          atm_d    = in_atm;
          sign_d   = sign_in;
          bypass_d = bypass;
          cnt_d    = '0;
          state_d  = DIV;
        end
      end
      DIV: begin
        if (cnt_q == CNT_W'(N)) begin
          out_pix_d   = bypass_q ? pix_q : j_vec;
          out_clamp_d = bypass_q ? 1'b0 : (|clamp_vec);
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pix_q       <= '0;
      atm_q       <= '0;
      sign_q      <= '0;
      bypass_q    <= 1'b0;
      out_pix_q   <= '0;
      out_clamp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pix_q       <= pix_d;
      atm_q       <= atm_d;
      sign_q      <= sign_d;
      bypass_q    <= bypass_d;
      out_pix_q   <= out_pix_d;
      out_clamp_q <= out_clamp_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign out_pix   = out_pix_q;
  assign out_clamp = out_clamp_q;

endmodule

// File: tb/tb_scene_recovery_pipe.sv
// Directed table-driven bench for scene_recovery_pipe plus handshake and reset corner sequences.
module tb_scene_recovery_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, bypass, out_valid, out_ready, out_clamp;
  logic [23:0] in_pix, in_atm, out_pix;
  logic [7:0]  in_t;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] pix;
    logic [23:0] atm;
    logic [7:0]  t;
    logic        byp;
    logic [23:0] exp_pix;
    logic        exp_clamp;
  } vec_t;

  vec_t tbl[10];

  always #5 clock = ~clock;

  scene_recovery_pipe dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_atm    (in_atm),
    .in_t      (in_t),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_clamp (out_clamp)
  );

  function automatic logic [23:0] p3(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic apply_beat(input vec_t v, input string nm);
    int lat;
    @(negedge clock);
    chk({nm, " in_ready_before"}, 32'(in_ready), 32'd1);
    in_pix = v.pix; in_atm = v.atm; in_t = v.t; bypass = v.byp; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk({nm, " latency"}, 32'(lat), 32'd17);
    chk({nm, " out_pix"}, 32'(out_pix), 32'(v.exp_pix));
    chk({nm, " out_clamp"}, 32'(out_clamp), 32'(v.exp_clamp));
    $display("beat %s: pix=%h atm=%h t=%0d byp=%0d -> out_pix=%h clamp=%0d lat=%0d",
             nm, v.pix, v.atm, v.t, v.byp, out_pix, out_clamp, lat);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({nm, " out_valid_after_ack"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    tbl[0] = '{p3(120,120,120), p3(100,100,100), 8'd128, 1'b0, p3(140,140,140), 1'b0};
    tbl[1] = '{p3(200,200,200), p3(100,100,100), 8'd128, 1'b0, p3(255,255,255), 1'b1};
    tbl[2] = '{p3(50,50,50),    p3(100,100,100), 8'd64,  1'b0, p3(0,0,0),       1'b1};
    tbl[3] = '{p3(90,90,90),    p3(100,100,100), 8'd200, 1'b0, p3(88,88,88),    1'b0};
    tbl[4] = '{p3(77,200,90),   p3(77,100,100),  8'd200, 1'b0, p3(77,228,88),   1'b0};
    tbl[5] = '{p3(110,110,110), p3(100,100,100), 8'd0,   1'b0, p3(198,198,198), 1'b0};
    tbl[6] = '{p3(110,110,110), p3(100,100,100), 8'd10,  1'b0, p3(198,198,198), 1'b0};
    tbl[7] = '{p3(200,50,120),  p3(100,100,100), 8'd128, 1'b1, p3(200,50,120),  1'b0};
    tbl[8] = '{p3(255,0,100),   p3(0,255,100),   8'd255, 1'b0, p3(255,0,100),   1'b1};
    tbl[9] = '{p3(101,101,101), p3(100,100,100), 8'd26,  1'b0, p3(109,109,109), 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bypass = 1'b0;
    in_pix = '0; in_atm = '0; in_t = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_pix", 32'(out_pix), 32'd0);
    chk("reset out_clamp", 32'(out_clamp), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) apply_beat(tbl[i], $sformatf("vec%0d", i));

    // Back-pressure in HOLD with in_valid held high throughout.
    @(negedge clock);
    in_pix = tbl[0].pix; in_atm = tbl[0].atm; in_t = tbl[0].t; bypass = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    wait_valid(lat);
    chk("hold latency", 32'(lat), 32'd17);
    in_pix = tbl[3].pix; in_atm = tbl[3].atm; in_t = tbl[3].t;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      chk($sformatf("hold%0d out_pix", c), 32'(out_pix), 32'(tbl[0].exp_pix));
      chk($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
      $display("hold cycle %0d: out_pix=%h in_ready=%0d", c, out_pix, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("hold->idle in_ready", 32'(in_ready), 32'd1);
    chk("hold->idle out_valid", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("second beat accepted", 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk("second beat latency", 32'(lat), 32'd17);
    chk("second beat out_pix", 32'(out_pix), 32'(tbl[3].exp_pix));
    $display("second beat: out_pix=%h lat=%0d", out_pix, lat);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;

    // Reset pulse four cycles into the divide drops the result.
    @(negedge clock);
    in_pix = tbl[1].pix; in_atm = tbl[1].atm; in_t = tbl[1].t; bypass = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("postreset out_valid", 32'(out_valid), 32'd0);
    chk("postreset in_ready", 32'(in_ready), 32'd1);
    chk("postreset out_pix", 32'(out_pix), 32'd0);
    chk("postreset out_clamp", 32'(out_clamp), 32'd0);
    $display("after mid-DIV reset: out_valid=%0d in_ready=%0d out_pix=%h", out_valid, in_ready, out_pix);
    apply_beat(tbl[0], "postreset_vec0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
